// File: rtl/peripheral_wb_pkg.sv
// Shared types and helpers for the Wishbone peripheral arbiter.
package peripheral_wb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_ERR,
    ARB_DRAIN
  } arb_state_t;

  // Index of the master after idx, wrapping back to 0 past the last one.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/peripheral_arbiter_rr_wb.sv
// Rotating-priority picker: one-hot grant for the first requester at or above ptr, wrapping.
module peripheral_arbiter_rr_wb #(
  parameter int NUM_MASTERS = 4,
  parameter int PW          = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PW-1:0]          ptr,
  output logic [NUM_MASTERS-1:0] gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (int'(ptr) + i) % NUM_MASTERS;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/peripheral_arbiter_wb.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS masters share one slave port, ownership held
// for a whole cyc, with a watchdog that converts a hung slave access into err.
module peripheral_arbiter_wb
  import peripheral_wb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 256
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,
  output logic [DW-1:0]               m_dat_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic                        s_rty_i,
  input  logic [DW-1:0]               s_dat_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int PW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW  = DW / 8;
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] pick;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          own;
  logic [PW-1:0]          own_next;
  logic [WDW-1:0]         wd_q, wd_d;
  logic                   term;

  peripheral_arbiter_rr_wb #(
    .NUM_MASTERS (NUM_MASTERS),
    .PW          (PW)
  ) u_rr (
    .req (m_cyc_i),
    .ptr (ptr_q),
    .gnt (pick)
  );

  always_comb begin
    own = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) own = PW'(i);
    end
  end

  assign own_next = PW'(rr_next(int'(own), NUM_MASTERS));
  assign term     = s_ack_i | s_err_i | s_rty_i;
  assign grant_o  = grant_q;
  assign m_dat_o  = s_dat_i;

  // Request fields always follow the owner; only cyc/stb are qualified by state.
  assign s_adr_o = m_adr_i[own*AW +: AW];
  assign s_dat_o = m_dat_i[own*DW +: DW];
  assign s_sel_o = m_sel_i[own*SW +: SW];
  assign s_we_o  = m_we_i[own];
  assign s_cti_o = m_cti_i[own*3 +: 3];
  assign s_bte_o = m_bte_i[own*2 +: 2];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    wd_d    = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    case (state_q)
      ARB_IDLE: begin
        if (|m_cyc_i) begin
          grant_d = pick;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        s_cyc_o      = m_cyc_i[own];
        s_stb_o      = m_cyc_i[own] & m_stb_i[own];
        m_ack_o[own] = s_ack_i;
        m_err_o[own] = s_err_i;
        m_rty_o[own] = s_rty_i;
        if (!m_cyc_i[own]) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          ptr_d   = own_next;
        end else if (TIMEOUT > 0 && s_stb_o && !term) begin
          // A termination arriving on the last permitted cycle still wins over the watchdog.
          if (wd_q == WD_LAST) state_d = ARB_ERR;
          else                 wd_d    = wd_q + WDW'(1);
        end
      end
      ARB_ERR: begin
        m_err_o[own] = 1'b1;
        state_d      = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (!m_cyc_i[own]) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          ptr_d   = own_next;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_peripheral_arbiter_wb.sv
// Directed bench for peripheral_arbiter_wb with a small registered-ack memory slave.
module tb_peripheral_arbiter_wb;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*AW-1:0]   m_adr = '0;
  logic [N*DW-1:0]   m_dat = '0;
  logic [N*DW/8-1:0] m_sel = '0;
  logic [N-1:0]      m_we = '0;
  logic [N*3-1:0]    m_cti = '0;
  logic [N*2-1:0]    m_bte = '0;
  logic [N-1:0]      m_cyc = '0;
  logic [N-1:0]      m_stb = '0;
  logic [N-1:0]      m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [DW-1:0]     m_dat_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel_o;
  logic              s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic              s_ack_i = 1'b0;
  logic              s_err_i = 1'b0;
  logic              s_rty_i = 1'b0;
  logic [DW-1:0]     s_dat_i = '0;

  peripheral_arbiter_wb #(
    .NUM_MASTERS (N),
    .AW          (AW),
    .DW          (DW),
    .TIMEOUT     (TO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat),
    .m_sel_i  (m_sel),
    .m_we_i   (m_we),
    .m_cti_i  (m_cti),
    .m_bte_i  (m_bte),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .m_rty_o  (m_rty_o),
    .m_dat_o  (m_dat_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_sel_o  (s_sel_o),
    .s_we_o   (s_we_o),
    .s_cti_o  (s_cti_o),
    .s_bte_o  (s_bte_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_ack_i  (s_ack_i),
    .s_err_i  (s_err_i),
    .s_rty_i  (s_rty_i),
    .s_dat_i  (s_dat_i),
    .grant_o  (grant_o)
  );

  // Memory slave: acks one beat two cycles after it sees a strobe; force_noack hangs it.
  logic [31:0] mem [0:255];
  logic        force_noack = 1'b0;
  int          slv_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n || !(s_cyc_o && s_stb_o) || s_ack_i) begin
      s_ack_i <= 1'b0;
      slv_cnt <= 0;
    end else if (!force_noack) begin
      if (slv_cnt == 1) begin
        s_ack_i <= 1'b1;
        slv_cnt <= 0;
        if (s_we_o) mem[s_adr_o[9:2]] <= s_dat_o;
        else        s_dat_i <= mem[s_adr_o[9:2]];
      end else begin
        slv_cnt <= slv_cnt + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setm(input int k, input logic cyc, input logic stb, input logic we,
                      input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    m_cyc[k]         = cyc;
    m_stb[k]         = stb;
    m_we[k]          = we;
    m_adr[k*AW +: AW] = adr;
    m_dat[k*DW +: DW] = dat;
    m_sel[k*4 +: 4]  = 4'hF;
    m_cti[k*3 +: 3]  = cti;
    m_bte[k*2 +: 2]  = 2'b00;
  endtask

  task automatic idle_m(input int k);
    setm(k, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
  endtask

  // Returns on the negedge where master k sees ack or err (current sample checked first).
  task automatic wait_term(input int k, output logic seen);
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (m_ack_o[k] || m_err_o[k]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  logic       seen;
  logic [3:0] prev_g;
  logic [3:0] order [$];
  logic       gap_ok, nonowner_ok;
  int         rem [4];
  int         beat, stb_cycles;

  initial begin
    // Reset held with every master requesting
    for (int k = 0; k < N; k++) setm(k, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_grant", grant_o, 4'b0000);
      chk("reset_scyc", s_cyc_o, 1'b0);
    end
    chk("reset_terms", {m_ack_o, m_err_o, m_rty_o, s_stb_o}, 13'h0);
    for (int k = 0; k < N; k++) idle_m(k);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write then read by m1
    @(negedge clk);
    setm(1, 1'b1, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 3'b000);
    @(negedge clk);
    chk("single_wr_grant", grant_o, 4'b0010);
    chk("single_wr_scyc", s_cyc_o, 1'b1);
    wait_term(1, seen);
    chk("single_wr_seen", seen, 1'b1);
    chk("single_wr_ack", {m_ack_o, m_err_o}, {4'b0010, 4'b0000});
    idle_m(1);
    @(negedge clk);
    chk("single_gap", grant_o, 4'b0000);
    setm(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b000);
    @(negedge clk);
    chk("single_rd_grant", grant_o, 4'b0010);
    wait_term(1, seen);
    chk("single_rd_seen", seen, 1'b1);
    chk("single_rd_ack", m_ack_o, 4'b0010);
    chk("single_rd_data", m_dat_o, 32'hCAFEF00D);
    idle_m(1);

    // Fairness from a fresh pointer: all four masters, two accesses each
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      setm(k, 1'b1, 1'b1, 1'b1, 32'h200 + k * 4, 32'h1000 + k, 3'b000);
      rem[k] = 2;
    end
    prev_g = grant_o;
    gap_ok = 1'b1;
    nonowner_ok = 1'b1;
    for (int c = 0; c < 300 && (rem[0] + rem[1] + rem[2] + rem[3]) > 0; c++) begin
      @(negedge clk);
      if (grant_o != 4'b0000 && grant_o != prev_g) begin
        order.push_back(grant_o);
        if (prev_g != 4'b0000) gap_ok = 1'b0;
      end
      if ((m_ack_o & ~grant_o) != 4'b0000) nonowner_ok = 1'b0;
      prev_g = grant_o;
      for (int k = 0; k < N; k++) begin
        if (m_ack_o[k]) begin
          rem[k]--;
          m_cyc[k] = 1'b0;
          m_stb[k] = 1'b0;
        end else if (!m_cyc[k] && rem[k] > 0) begin
          m_cyc[k] = 1'b1;
          m_stb[k] = 1'b1;
        end
      end
    end
    chk("fair_all_done", rem[0] + rem[1] + rem[2] + rem[3], 0);
    chk("fair_grants", order.size(), 8);
    chk("fair_order0", (order.size() > 0) ? order[0] : 4'h0, 4'b0001);
    chk("fair_order1", (order.size() > 1) ? order[1] : 4'h0, 4'b0010);
    chk("fair_order2", (order.size() > 2) ? order[2] : 4'h0, 4'b0100);
    chk("fair_order3", (order.size() > 3) ? order[3] : 4'h0, 4'b1000);
    chk("fair_order4", (order.size() > 4) ? order[4] : 4'h0, 4'b0001);
    chk("fair_idle_gap", gap_ok, 1'b1);
    chk("fair_nonowner_ack", nonowner_ok, 1'b1);
    for (int k = 0; k < N; k++) idle_m(k);

    // m2 incrementing burst while m0 waits
    @(negedge clk);
    setm(2, 1'b1, 1'b1, 1'b1, 32'h100, 32'hD0000000, 3'b010);
    @(negedge clk);
    chk("burst_grant", grant_o, 4'b0100);
    setm(0, 1'b1, 1'b1, 1'b0, 32'h108, 32'h0, 3'b000);
    beat = 0;
    for (int c = 0; c < 80 && beat < 4; c++) begin
      @(negedge clk);
      if (m_ack_o[2]) begin
        chk("burst_hold", {m_ack_o, grant_o}, {4'b0100, 4'b0100});
        beat++;
        if (beat < 4)
          setm(2, 1'b1, 1'b1, 1'b1, 32'h100 + beat * 4, 32'hD0000000 + beat,
               (beat == 3) ? 3'b111 : 3'b010);
        else
          idle_m(2);
      end
    end
    chk("burst_beats", beat, 4);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      prev_g = grant_o;
      @(negedge clk);
      if (grant_o == 4'b0001) begin
        seen = 1'b1;
        break;
      end
    end
    chk("burst_m0_granted", seen, 1'b1);
    chk("burst_gap", prev_g, 4'b0000);
    wait_term(0, seen);
    chk("burst_rd_seen", seen, 1'b1);
    chk("burst_rd_data", m_dat_o, 32'hD0000002);
    idle_m(0);

    // Watchdog: hung slave, m1 owner, m3 waiting
    @(negedge clk);
    force_noack = 1'b1;
    setm(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b000);
    stb_cycles = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_err_o[1]) begin
        seen = 1'b1;
        break;
      end
      if (s_stb_o) stb_cycles++;
    end
    chk("wd_err_seen", seen, 1'b1);
    chk("wd_stb_cycles", stb_cycles, TO);
    chk("wd_err_vec", {m_err_o, m_ack_o}, {4'b0010, 4'b0000});
    chk("wd_err_scyc", {s_cyc_o, s_stb_o}, 2'b00);
    m_stb[1] = 1'b0;
    setm(3, 1'b1, 1'b1, 1'b1, 32'h44, 32'h33, 3'b000);
    @(negedge clk);
    chk("wd_err_pulse", m_err_o, 4'b0000);
    chk("wd_drain_scyc", s_cyc_o, 1'b0);
    @(negedge clk);
    chk("wd_drain_hold", grant_o, 4'b0010);
    idle_m(1);
    force_noack = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (grant_o == 4'b1000) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wd_next_granted", seen, 1'b1);
    wait_term(3, seen);
    chk("wd_m3_ack", {seen, m_ack_o}, {1'b1, 4'b1000});
    idle_m(3);

    // Move the pointer to 2, then reset in the middle of an m3 burst
    @(negedge clk);
    setm(1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 3'b000);
    @(negedge clk);
    wait_term(1, seen);
    chk("ptr_move_ack", seen, 1'b1);
    idle_m(1);
    @(negedge clk);
    setm(3, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 3'b010);
    @(negedge clk);
    wait_term(3, seen);
    chk("mid_beat1", seen, 1'b1);
    setm(3, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 3'b010);
    setm(0, 1'b1, 1'b1, 1'b0, 32'h108, 32'h0, 3'b000);
    setm(2, 1'b1, 1'b1, 1'b0, 32'h10C, 32'h0, 3'b000);
    @(negedge clk);
    chk("mid_owner", {grant_o, s_cyc_o}, {4'b1000, 1'b1});
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset_drop", {grant_o, s_cyc_o, m_ack_o}, {4'b0000, 1'b0, 4'b0000});
    rst_n = 1'b1;
    idle_m(3);
    @(negedge clk);
    chk("mid_post_grant", grant_o, 4'b0001);
    wait_term(0, seen);
    chk("mid_m0_data", {seen, m_dat_o}, {1'b1, 32'hD0000002});
    for (int k = 0; k < N; k++) idle_m(k);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
